// File: rtl/mem_sequencer.sv
// Load/store sequencer: one or two aligned 32-bit bus beats per core memory op.
// Optional macro MEM_SEQ_MISALIGNED_SPLIT_EN enables two-beat word-crossing accesses.
module mem_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [3:0]        iobytes,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_off;
  logic [3:0]          r_iobytes;
  logic                r_sext;
  logic                r_store;
  logic                r_done;
  logic                r_fault;
  logic [31:0]         r_rdata;
  logic                r_bus_valid;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [3:0]          r_bus_be;
  logic [31:0]         r_bus_wdata;

  logic [1:0]          w_off;
  logic [7:0]          w_mask8;
  logic [31:0]         w_wdata_lo;
  logic                w_split;
  logic                w_bad_size;
  logic                w_fault;

`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
  logic                r_split;
  logic [3:0]          r_be_hi;
  logic [31:0]         r_wdata_hi;
  logic [31:0]         r_lo;
  logic [31:0]         r_hi;
  logic [31:0]         w_wdata_hi;
`endif

  // Shift the {hi,lo} window down to the addressed byte, then mask and extend.
  function automatic logic [31:0] f_load_fmt(input logic [63:0] raw64, input logic [1:0] off,
                                             input logic [3:0] iob, input logic sx);
    logic [63:0] sh;
    logic [31:0] res;
    sh = raw64 >> {off, 3'b000};
    case (iob)
      4'b0001: res = {{24{sx & sh[7]}}, sh[7:0]};
      4'b0011: res = {{16{sx & sh[15]}}, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  // Lane mask, positioned store data and fault classification from the raw request.
  always_comb begin
    w_off      = addr[1:0];
    w_mask8    = {4'b0000, iobytes} << w_off;
    w_split    = |w_mask8[7:4];
    w_bad_size = !((iobytes == 4'b0001) || (iobytes == 4'b0011) || (iobytes == 4'b1111));
`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
    {w_wdata_hi, w_wdata_lo} = {32'h0000_0000, wdata} << {w_off, 3'b000};
    w_fault    = w_bad_size;
`else
    w_wdata_lo = wdata << {w_off, 3'b000};
    w_fault    = w_bad_size | w_split;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_fault ? RESP : BEAT0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BEAT0: begin
        if (bus_ready) begin
`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
          w_state_nxt = r_split ? BEAT1 : RESP;
`else
          w_state_nxt = RESP;
`endif
        end else begin
          w_state_nxt = BEAT0;
        end
      end
`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
      BEAT1: begin
        if (bus_ready) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = BEAT1;
        end
      end
`endif
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, bus beat registers and response formation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off       <= 2'b00;
      r_iobytes   <= 4'b0000;
      r_sext      <= 1'b0;
      r_store     <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0000_0000;
`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
      r_split     <= 1'b0;
      r_be_hi     <= 4'b0000;
      r_wdata_hi  <= 32'h0000_0000;
      r_lo        <= 32'h0000_0000;
      r_hi        <= 32'h0000_0000;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start && w_fault) begin
            r_done  <= 1'b1;
            r_fault <= 1'b1;
            r_rdata <= 32'h0000_0000;
          end else if (start) begin
            r_off       <= w_off;
            r_iobytes   <= iobytes;
            r_sext      <= sext;
            r_store     <= is_store;
            r_bus_valid <= 1'b1;
            r_bus_we    <= is_store;
            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_bus_be    <= w_mask8[3:0];
            r_bus_wdata <= w_wdata_lo;
`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
            r_split     <= w_split;
            r_be_hi     <= w_mask8[7:4];
            r_wdata_hi  <= w_wdata_hi;
`endif
          end
        end
        BEAT0: begin
          if (bus_ready) begin
`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
            r_lo <= bus_rdata;
            if (r_split) begin
              r_bus_addr  <= r_bus_addr + ADDR_W'(4);
              r_bus_be    <= r_be_hi;
              r_bus_wdata <= r_wdata_hi;
            end else begin
              r_bus_valid <= 1'b0;
              r_done      <= 1'b1;
              r_rdata     <= r_store ? 32'h0000_0000
                           : f_load_fmt({32'h0000_0000, bus_rdata}, r_off, r_iobytes, r_sext);
            end
`else
            r_bus_valid <= 1'b0;
            r_done      <= 1'b1;
            r_rdata     <= r_store ? 32'h0000_0000
                         : f_load_fmt({32'h0000_0000, bus_rdata}, r_off, r_iobytes, r_sext);
`endif
          end
        end
`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
        BEAT1: begin
          if (bus_ready) begin
            r_hi        <= bus_rdata;
            r_bus_valid <= 1'b0;
            r_done      <= 1'b1;
            r_rdata     <= r_store ? 32'h0000_0000
                         : f_load_fmt({bus_rdata, r_lo}, r_off, r_iobytes, r_sext);
          end
        end
`endif
        RESP: begin
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          r_rdata <= 32'h0000_0000;
        end
        default: begin
          r_done      <= 1'b0;
          r_fault     <= 1'b0;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign stall     = (r_state == BEAT0) | (r_state == BEAT1) | ((r_state == IDLE) & start);
  assign done      = r_done;
  assign fault     = r_fault;
  assign rdata     = r_rdata;
  assign bus_valid = r_bus_valid;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed, table-driven bench for mem_sequencer; expectations follow MEM_SEQ_MISALIGNED_SPLIT_EN.
module tb_mem_sequencer;

`ifdef MEM_SEQ_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [3:0]  iobytes = 4'b0000;
  logic        sext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, fault, bus_valid, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .iobytes(iobytes),
    .sext(sext), .addr(addr), .wdata(wdata), .stall(stall), .done(done), .fault(fault),
    .rdata(rdata), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit          st;
    logic [3:0]  iob;
    bit          sx;
    logic [31:0] a, wd, r0, r1;
    bit          flt;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0, a1;
    logic [3:0]  be1;
    logic [31:0] wd1, rd;
  } vec_t;

  function automatic vec_t mk(input bit st, input logic [3:0] iob, input bit sx,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] r0,
                              input logic [31:0] r1, input bit flt, input int beats,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                              input logic [31:0] rd);
    vec_t v;
    v.st = st; v.iob = iob; v.sx = sx; v.a = a; v.wd = wd; v.r0 = r0; v.r1 = r1;
    v.flt = flt; v.beats = beats; v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
    v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    start = 1'b1; is_store = v.st; iobytes = v.iob; sext = v.sx; addr = v.a; wdata = v.wd;
    bus_ready = 1'b1; bus_rdata = v.r0;
    #1 chk({p, "_stall_c0"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0; addr = 32'hDEAD_0000; wdata = ~v.wd; iobytes = 4'b1111; sext = ~v.sx;
    if (v.flt) begin
      chk({p, "_done_c1"}, 32'(done), 32'd1);
      chk({p, "_fault_c1"}, 32'(fault), 32'd1);
      chk({p, "_valid_c1"}, 32'(bus_valid), 32'd0);
    end else begin
      chk({p, "_valid_b0"}, 32'(bus_valid), 32'd1);
      chk({p, "_addr_b0"}, bus_addr, v.a0);
      chk({p, "_be_b0"}, 32'(bus_be), 32'(v.be0));
      chk({p, "_we_b0"}, 32'(bus_we), 32'(v.st));
      chk({p, "_done_b0"}, 32'(done), 32'd0);
      if (v.st) chk({p, "_wdata_b0"}, bus_wdata, v.wd0);
      if (v.beats == 2) begin
        @(negedge clk);
        bus_rdata = v.r1;
        chk({p, "_valid_b1"}, 32'(bus_valid), 32'd1);
        chk({p, "_addr_b1"}, bus_addr, v.a1);
        chk({p, "_be_b1"}, 32'(bus_be), 32'(v.be1));
        chk({p, "_stall_b1"}, 32'(stall), 32'd1);
        if (v.st) chk({p, "_wdata_b1"}, bus_wdata, v.wd1);
      end
      @(negedge clk);
      chk({p, "_done"}, 32'(done), 32'd1);
      chk({p, "_fault"}, 32'(fault), 32'd0);
      chk({p, "_rdata"}, rdata, v.rd);
      chk({p, "_stall_resp"}, 32'(stall), 32'd0);
      chk({p, "_valid_resp"}, 32'(bus_valid), 32'd0);
    end
    @(negedge clk);
    bus_ready = 1'b0;
    chk({p, "_done_after"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(0, 4'b1111, 0, 32'h100, 32'h0, 32'h89ABCDEF, 32'h0, 0, 1,
                  32'h100, 4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h89ABCDEF);
    vecs[1]  = mk(0, 4'b0001, 1, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 1,
                  32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80);
    vecs[2]  = mk(0, 4'b0001, 0, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 1,
                  32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00000080);
    vecs[3]  = mk(0, 4'b0011, 1, 32'h101, 32'h0, 32'h12F00D34, 32'h0, 0, 1,
                  32'h100, 4'b0110, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFFF00D);
    vecs[4]  = mk(0, 4'b0011, 0, 32'h102, 32'h0, 32'h80010000, 32'h0, 0, 1,
                  32'h100, 4'b1100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00008001);
    vecs[5]  = mk(1, 4'b1111, 0, 32'h300, 32'hDEADBEEF, 32'h12345678, 32'h0, 0, 1,
                  32'h300, 4'b1111, 32'hDEADBEEF, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[6]  = mk(1, 4'b0001, 0, 32'h301, 32'h000000A5, 32'h0, 32'h0, 0, 1,
                  32'h300, 4'b0010, 32'h0000A500, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[7]  = mk(0, 4'b0000, 0, 32'h100, 32'h0, 32'h0, 32'h0, 1, 0,
                  32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[8]  = mk(0, 4'b0111, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0,
                  32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[9]  = mk(0, 4'b1111, 0, 32'h1FE, 32'h0, 32'hAABB5566, 32'h99881122, !SPLIT, SPLIT ? 2 : 0,
                  32'h1FC, 4'b1100, 32'h0, 32'h200, 4'b0011, 32'h0, 32'h1122AABB);
    vecs[10] = mk(1, 4'b0011, 0, 32'h303, 32'h00001234, 32'h0, 32'h0, !SPLIT, SPLIT ? 2 : 0,
                  32'h300, 4'b1000, 32'h34000000, 32'h304, 4'b0001, 32'h00000012, 32'h0);
    vecs[11] = mk(0, 4'b1111, 0, 32'hFFFFFFFD, 32'h0, 32'h11223344, 32'h55667788, !SPLIT,
                  SPLIT ? 2 : 0, 32'hFFFFFFFC, 4'b1110, 32'h0, 32'h00000000, 4'b0001, 32'h0,
                  32'h88112233);

    // Reset state
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_wdata", bus_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Half store with three wait cycles: bus must hold steady and stall stay high
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; iobytes = 4'b0011; sext = 1'b0; addr = 32'h202;
    wdata = 32'h0000BEEF; bus_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0; wdata = 32'h0; addr = 32'h0;
      chk($sformatf("wait%0d_valid", c), 32'(bus_valid), 32'd1);
      chk($sformatf("wait%0d_addr", c), bus_addr, 32'h200);
      chk($sformatf("wait%0d_be", c), 32'(bus_be), 32'b1100);
      chk($sformatf("wait%0d_wdata", c), bus_wdata, 32'hBEEF0000);
      chk($sformatf("wait%0d_we", c), 32'(bus_we), 32'd1);
      chk($sformatf("wait%0d_stall", c), 32'(stall), 32'd1);
      chk($sformatf("wait%0d_done", c), 32'(done), 32'd0);
    end
    bus_ready = 1'b1;
    @(negedge clk);
    chk("wait_done", 32'(done), 32'd1);
    chk("wait_stall", 32'(stall), 32'd0);
    @(negedge clk);
    bus_ready = 1'b0;
    chk("wait_done_after", 32'(done), 32'd0);

    // Reset while BEAT0 is waiting for ready
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; iobytes = 4'b1111; addr = 32'h400; bus_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rmid_valid_pre", 32'(bus_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmid_valid_async", 32'(bus_valid), 32'd0);
    chk("rmid_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rmid_done%0d", c), 32'(done), 32'd0);
      chk($sformatf("rmid_valid%0d", c), 32'(bus_valid), 32'd0);
    end
    bus_ready = 1'b0;
    run_vec(vecs[0], 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
